// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter: default widths, the
// sequencing FSM state encoding and the latched access command.
package dmem_arb_pkg;

  localparam int ARB_AW = 13;
  localparam int ARB_DW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // One memory command as captured from the winning requester.
  typedef struct packed {
    logic              we;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/dmem_rr_pick2.sv
// Combinational two-way round-robin picker. A sole requester always wins;
// on a tie the port that did not win last time gets the slot.
module dmem_rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  assign winner = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one combinational-read data memory between port 0 (CPU data side)
// and port 1 (DMA/debug loader). Each access runs IDLE -> ACCESS -> DONE,
// with the memory strobe held for WAIT_STATES+1 cycles.
// Optional build macro DMEM_ARB_LOCK_EN adds lock0/lock1: a winner holding
// its lock high in DONE is re-issued straight into ACCESS, keeping the
// other port out for atomic read-modify-write sequences.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW          = ARB_AW,
  parameter int DW          = ARB_DW,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          done0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          done1,
  output logic [DW-1:0] rdata1,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_abus,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [3:0] WS_L = 4'(WAIT_STATES);

  state_t     state, state_n;
  cmd_t       cmd_l, cmd_n, cmd0, cmd1;
  logic       last, last_n;
  logic       win_l, win_n;
  logic [3:0] cnt, cnt_n;
  logic       pick_valid, pick_winner;
  logic [1:0] gnt_c, done_c;
  logic       capture;

  assign cmd0 = '{we: we0, addr: addr0, wdata: wdata0};
  assign cmd1 = '{we: we1, addr: addr1, wdata: wdata1};

  dmem_rr_pick2 u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Next-state, arbitration and memory-strobe decode.
  always_comb begin
    state_n   = state;
    cmd_n     = cmd_l;
    last_n    = last;
    win_n     = win_l;
    cnt_n     = cnt;
    gnt_c     = 2'b00;
    done_c    = 2'b00;
    capture   = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_abus  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          gnt_c[pick_winner] = 1'b1;
          cmd_n   = pick_winner ? cmd1 : cmd0;
          last_n  = pick_winner;
          win_n   = pick_winner;
          cnt_n   = WS_L;
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        mem_abus  = cmd_l.addr;
        mem_wdata = cmd_l.wdata;
        mem_rd    = ~cmd_l.we;
        mem_wr    = cmd_l.we;
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          capture = ~cmd_l.we;
          state_n = DONE;
        end
      end
      DONE: begin
        done_c[win_l] = 1'b1;
        state_n       = IDLE;
`ifdef DMEM_ARB_LOCK_EN
        // Locked winner keeps the memory: re-issue its current command.
        if (win_l ? lock1 : lock0) begin
          gnt_c[win_l] = 1'b1;
          cmd_n        = win_l ? cmd1 : cmd0;
          cnt_n        = WS_L;
          state_n      = ACCESS;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // Grants are combinational in IDLE; keep them quiet while reset is held.
  assign gnt0  = gnt_c[0] & ~reset;
  assign gnt1  = gnt_c[1] & ~reset;
  assign done0 = done_c[0];
  assign done1 = done_c[1];
  assign busy  = (state != IDLE);

  // State, arbitration history, wait counter, command latch and read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      last   <= 1'b1;
      win_l  <= 1'b0;
      cnt    <= 4'd0;
      cmd_l  <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      win_l <= win_n;
      cnt   <= cnt_n;
      cmd_l <= cmd_n;
      if (capture) begin
        if (win_l) rdata1 <= mem_rdata;
        else       rdata0 <= mem_rdata;
      end
    end
  end

endmodule
